// File: rtl/sm_pio_pkg.sv
// Shared constants for the SM PIO family: register map, edge-mode encodings, bus width.
package sm_pio_pkg;

  localparam int unsigned RD_W = 32;

  typedef logic [RD_W-1:0] rd_word_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/sm_pio_in_edge_if.sv
// Avalon-MM slave bus used by the SM PIO blocks: fixed 2-bit address, 32-bit data.
interface sm_pio_in_edge_if;
  import sm_pio_pkg::*;

  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  rd_word_t   writedata;
  rd_word_t   readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/sm_sync_chain.sv
// Multi-flop synchroniser with synchronous active-high reset; DEPTH 0 is a plain wire.
module sm_sync_chain #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;
    assign o_q = i_d;
  end else begin : g_flops
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_stage[i] <= '0;
        end
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < int'(DEPTH); i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/sm_pio_in_edge.sv
// Memory-mapped input port with synchroniser, sticky per-bit edge capture and maskable irq.
module sm_pio_in_edge
  import sm_pio_pkg::*;
#(
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter logic [DATA_W-1:0] RESET_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  sm_pio_in_edge_if.slave   bus,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  logic [DATA_W-1:0] w_sync_in;
  logic [DATA_W-1:0] w_rise;
  logic [DATA_W-1:0] w_fall;
  logic [DATA_W-1:0] w_edge;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_clr;
  logic [DATA_W-1:0] w_capture_nxt;
  logic              w_wr;
  rd_word_t          w_rd_nxt;
  logic              w_unused_wdata;

  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_capture;
  logic [DATA_W-1:0] r_mask;
  rd_word_t          r_readdata;
  logic              r_irq;

  sm_sync_chain #(
    .WIDTH (DATA_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_port),
    .o_q   (w_sync_in)
  );

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_wdata        = bus.writedata[DATA_W-1:0];
  assign w_unused_wdata = ^bus.writedata;

  always_comb begin
    w_rise = w_sync_in & ~r_prev;
    w_fall = ~w_sync_in & r_prev;
    case (EDGE_TYPE)
      EDGE_FALL: w_edge = w_fall;
      EDGE_ANY:  w_edge = w_rise | w_fall;
      default:   w_edge = w_rise;
    endcase
  end

  // Edge is ORed in after the clear so a same-cycle edge always wins.
  always_comb begin
    w_clr         = (w_wr && (bus.address == ADDR_EDGE)) ? w_wdata : '0;
    w_capture_nxt = (r_capture & ~w_clr) | w_edge;
  end

  always_comb begin
    w_rd_nxt = '0;
    unique case (bus.address)
      ADDR_DATA: w_rd_nxt[DATA_W-1:0] = w_sync_in;
      ADDR_RSVD: w_rd_nxt = '0;
      ADDR_MASK: w_rd_nxt[DATA_W-1:0] = r_mask;
      ADDR_EDGE: w_rd_nxt[DATA_W-1:0] = r_capture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_capture  <= '0;
      r_mask     <= RESET_MASK;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_sync_in;
      r_capture  <= w_capture_nxt;
      if (w_wr && (bus.address == ADDR_MASK)) begin
        r_mask <= w_wdata;
      end
      r_readdata <= w_rd_nxt;
      r_irq      <= |(r_capture & r_mask);
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_sm_pio_in_edge.sv
// Scoreboard bench: three 8-bit PIOs (rise, fall, any edge); reads push expectations, monitor checks.
module tb_sm_pio_in_edge;
  import sm_pio_pkg::*;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  int          sel;
  logic        rd_strobe;
  logic        rd_q = 1'b0;
  logic        end_req = 1'b0;
  logic        end_ack = 1'b0;
  logic [7:0]  pin  [3];
  logic [31:0] rdw  [3];
  logic        irqw [3];

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  m_e;
  string m_nm;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  sm_pio_in_edge_if bus0 ();
  sm_pio_in_edge_if bus1 ();
  sm_pio_in_edge_if bus2 ();

  assign bus0.address = address;
  assign bus1.address = address;
  assign bus2.address = address;
  assign bus0.write_n = wn;
  assign bus1.write_n = wn;
  assign bus2.write_n = wn;
  assign bus0.writedata = wd;
  assign bus1.writedata = wd;
  assign bus2.writedata = wd;
  assign bus0.chipselect = cs && (sel == 0);
  assign bus1.chipselect = cs && (sel == 1);
  assign bus2.chipselect = cs && (sel == 2);
  assign rdw[0] = bus0.readdata;
  assign rdw[1] = bus1.readdata;
  assign rdw[2] = bus2.readdata;

  sm_pio_in_edge #(
    .DATA_W (8), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_RISE), .RESET_MASK (8'h00)
  ) u_rise (
    .clk (clk), .reset (reset), .bus (bus0), .in_port (pin[0]), .irq (irqw[0])
  );

  sm_pio_in_edge #(
    .DATA_W (8), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_FALL), .RESET_MASK (8'h00)
  ) u_fall (
    .clk (clk), .reset (reset), .bus (bus1), .in_port (pin[1]), .irq (irqw[1])
  );

  sm_pio_in_edge #(
    .DATA_W (8), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_ANY), .RESET_MASK (8'h5A)
  ) u_any (
    .clk (clk), .reset (reset), .bus (bus2), .in_port (pin[2]), .irq (irqw[2])
  );

  // A read issued in one slot is presented one edge later.
  always @(posedge clk) rd_q <= rd_strobe;

  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got readdata with no expectation queued, want none");
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        total++;
        if (rdw[m_e.dut] !== m_e.rd) begin
          bad++;
          $display("FAIL %s readdata: got %h want %h", m_nm, rdw[m_e.dut], m_e.rd);
        end
        total++;
        if (irqw[m_e.dut] !== m_e.irq) begin
          bad++;
          $display("FAIL %s irq: got %b want %b", m_nm, irqw[m_e.dut], m_e.irq);
        end
      end
    end
    if (end_req && !end_ack) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
      end
      end_ack <= 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cs        = 1'b0;
    wn        = 1'b1;
    rd_strobe = 1'b0;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] er, input logic ei,
                    input string nm);
    exp_t e;
    sel       = d;
    address   = a;
    cs        = 1'b1;
    wn        = 1'b1;
    rd_strobe = 1'b1;
    e.dut     = 2'(d);
    e.rd      = er;
    e.irq     = ei;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc();
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    sel     = d;
    address = a;
    wd      = v;
    cs      = 1'b1;
    wn      = 1'b0;
    cyc();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    reset     = 1'b1;
    sel       = 0;
    address   = ADDR_DATA;
    cs        = 1'b0;
    wn        = 1'b1;
    wd        = '0;
    rd_strobe = 1'b0;
    for (int i = 0; i < 3; i++) pin[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    rd(0, ADDR_DATA, 32'h0, 1'b0, "rst_data");
    rd(0, ADDR_RSVD, 32'h0, 1'b0, "rst_rsvd");
    rd(0, ADDR_MASK, 32'h0, 1'b0, "rst_mask");
    rd(0, ADDR_EDGE, 32'h0, 1'b0, "rst_edge");
    rd(2, ADDR_MASK, 32'h5A, 1'b0, "rst_mask_nonzero");

    // Two sync flops plus the read register: first visible on the third read.
    pin[0] = 8'hA5;
    rd(0, ADDR_DATA, 32'h0, 1'b0, "sync_lat1");
    rd(0, ADDR_DATA, 32'h0, 1'b0, "sync_lat2");
    rd(0, ADDR_DATA, 32'hA5, 1'b0, "sync_lat3");
    rd(0, ADDR_DATA, 32'hA5, 1'b0, "sync_hold");
    rd(0, ADDR_EDGE, 32'hA5, 1'b0, "cap_unmasked");
    wr(0, ADDR_EDGE, 32'hFF);
    rd(0, ADDR_EDGE, 32'h0, 1'b0, "cap_clear_all");
    wr(0, ADDR_MASK, 32'hFFFF_FF01);
    rd(0, ADDR_MASK, 32'h01, 1'b0, "mask_upper_bits");

    pin[0] = 8'hA4;
    idle(4);
    rd(0, ADDR_EDGE, 32'h0, 1'b0, "rise_ignores_fall");
    pin[0] = 8'hA5;
    idle(2);
    rd(0, ADDR_EDGE, 32'h0, 1'b0, "rise_pre");
    rd(0, ADDR_EDGE, 32'h1, 1'b1, "rise_cap_irq");
    rd(0, ADDR_EDGE, 32'h1, 1'b1, "rise_irq_hold");
    wr(0, ADDR_EDGE, 32'h1);
    rd(0, ADDR_EDGE, 32'h0, 1'b0, "rise_clear_irq");

    pin[1] = 8'hFF;
    idle(4);
    rd(1, ADDR_EDGE, 32'h0, 1'b0, "fall_ignores_rise");
    pin[1] = 8'hF7;
    idle(3);
    rd(1, ADDR_EDGE, 32'h08, 1'b0, "fall_cap_masked");
    wr(1, ADDR_MASK, 32'h08);
    rd(1, ADDR_MASK, 32'h08, 1'b1, "unmask_irq");
    wr(1, ADDR_MASK, 32'h00);
    rd(1, ADDR_EDGE, 32'h08, 1'b0, "remask_irq_low");

    wr(2, ADDR_MASK, 32'h04);
    pin[2] = 8'h04;
    idle(5);
    rd(2, ADDR_EDGE, 32'h04, 1'b1, "any_rise_cap");
    pin[2] = 8'h00;
    idle(2);
    wr(2, ADDR_EDGE, 32'h04);
    rd(2, ADDR_EDGE, 32'h04, 1'b1, "collide_edge_wins");
    rd(2, ADDR_EDGE, 32'h04, 1'b1, "collide_hold");
    wr(2, ADDR_EDGE, 32'h04);
    rd(2, ADDR_EDGE, 32'h0, 1'b0, "clear_no_collide");

    wr(2, ADDR_MASK, 32'hFF);
    pin[2] = 8'hFF;
    idle(4);
    rd(2, ADDR_EDGE, 32'hFF, 1'b1, "pre_reset_cap");
    reset = 1'b1;
    rd(2, ADDR_EDGE, 32'h0, 1'b0, "reset_overrides_read");
    reset = 1'b0;
    rd(2, ADDR_EDGE, 32'h0, 1'b0, "post_reset_cap");
    rd(2, ADDR_MASK, 32'h5A, 1'b0, "post_reset_mask");
    rd(2, ADDR_DATA, 32'hFF, 1'b0, "post_reset_sync");
    rd(2, ADDR_EDGE, 32'hFF, 1'b1, "post_reset_recapture");

    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_ack; i++) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
